// File: rtl/test_status_responder.sv
// Target side of the test pass/fail handshake: decodes HTIF-style tohost
// writes (exit, putchar) into sticky status outputs, with an idle watchdog.
module test_status_responder #(
  parameter int                 DATA_W      = 64,
  parameter int                 ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]  TOHOST_ADDR = 32'h8000_1000,
  parameter int                 IDLE_W      = 32,
  parameter logic [IDLE_W-1:0]  MAX_IDLE    = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              char_valid,
  input  logic              char_ready,
  output logic [7:0]        char_data,
  output logic              fromhost_valid,
  output logic [DATA_W-1:0] fromhost_data,
  output logic              success,
  output logic              failure,
  output logic              timeout,
  output logic [DATA_W-2:0] fail_code
);

  typedef enum logic [1:0] {
    RUN,
    CHAR_WAIT,
    DONE_PASS,
    DONE_FAIL
  } state_e;

  localparam logic [IDLE_W-1:0] IDLE_LAST = MAX_IDLE - 1'b1;
  localparam logic [DATA_W-1:0] ACK_WORD  = {16'h0101, 48'h1};

  state_e              state_q, state_d;
  logic                char_valid_q, char_valid_d;
  logic [7:0]          char_data_q, char_data_d;
  logic                fh_valid_q, fh_valid_d;
  logic [DATA_W-1:0]   fh_data_q, fh_data_d;
  logic                success_q, success_d;
  logic                failure_q, failure_d;
  logic                timeout_q, timeout_d;
  logic [DATA_W-2:0]   fail_code_q, fail_code_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;

  logic                accept;
  logic                wd_fire;
  logic                is_tohost;
  logic                is_clear;
  logic                is_exit;
  logic                is_putc;
  logic [DATA_W-2:0]   code;
  logic [IDLE_W-1:0]   idle_inc;

  assign wr_ready  = (state_q == RUN);
  assign accept    = wr_valid && wr_ready;
  assign is_tohost = (wr_addr == TOHOST_ADDR);
  assign code      = wr_data[DATA_W-1:1];
  assign is_clear  = (wr_data == '0);
  assign is_exit   = (wr_data[63:56] == 8'h00) && wr_data[0];
  assign is_putc   = (wr_data[63:48] == 16'h0101);
  assign idle_inc  = (&idle_cnt_q) ? idle_cnt_q : idle_cnt_q + 1'b1;

  // A write accepted this cycle always beats the watchdog.
  assign wd_fire = (MAX_IDLE != '0) && (idle_cnt_q == IDLE_LAST)
                && !accept
                && (state_q == RUN || state_q == CHAR_WAIT);

  always_comb begin
    state_d      = state_q;
    char_valid_d = char_valid_q;
    char_data_d  = char_data_q;
    fh_valid_d   = fh_valid_q;
    fh_data_d    = fh_data_q;
    success_d    = success_q;
    failure_d    = failure_q;
    timeout_d    = timeout_q;
    fail_code_d  = fail_code_q;
    idle_cnt_d   = idle_cnt_q;

    if (state_q == RUN || state_q == CHAR_WAIT) begin
      fh_valid_d = 1'b0;
      idle_cnt_d = idle_inc;
    end

    if (wd_fire) begin
      state_d      = DONE_FAIL;
      failure_d    = 1'b1;
      timeout_d    = 1'b1;
      fail_code_d  = '0;
      char_valid_d = 1'b0;
    end else if (state_q == CHAR_WAIT) begin
      if (char_ready) begin
        state_d      = RUN;
        char_valid_d = 1'b0;
        fh_valid_d   = 1'b1;
        fh_data_d    = ACK_WORD;
        idle_cnt_d   = '0;
      end
    end else if (accept) begin
      idle_cnt_d = '0;
      if (is_tohost) begin
        unique case (1'b1)
          is_clear: ;
          is_exit: begin
            if (code == '0) begin
              state_d   = DONE_PASS;
              success_d = 1'b1;
            end else begin
              state_d     = DONE_FAIL;
              failure_d   = 1'b1;
              fail_code_d = code;
            end
          end
          is_putc: begin
            state_d      = CHAR_WAIT;
            char_valid_d = 1'b1;
            char_data_d  = wr_data[7:0];
          end
          default: begin
            state_d     = DONE_FAIL;
            failure_d   = 1'b1;
            fail_code_d = '1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= RUN;
      char_valid_q <= 1'b0;
      char_data_q  <= '0;
      fh_valid_q   <= 1'b0;
      fh_data_q    <= '0;
      success_q    <= 1'b0;
      failure_q    <= 1'b0;
      timeout_q    <= 1'b0;
      fail_code_q  <= '0;
      idle_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      char_valid_q <= char_valid_d;
      char_data_q  <= char_data_d;
      fh_valid_q   <= fh_valid_d;
      fh_data_q    <= fh_data_d;
      success_q    <= success_d;
      failure_q    <= failure_d;
      timeout_q    <= timeout_d;
      fail_code_q  <= fail_code_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

  assign char_valid     = char_valid_q;
  assign char_data      = char_data_q;
  assign fromhost_valid = fh_valid_q;
  assign fromhost_data  = fh_data_q;
  assign success        = success_q;
  assign failure        = failure_q;
  assign timeout        = timeout_q;
  assign fail_code      = fail_code_q;

endmodule
